// File: rtl/sysarr_pkg.sv
// Shared types and default sizing for the systolic-array input feeder.
package sysarr_pkg;

  localparam int unsigned DATA_BW_DEF     = 8;
  localparam int unsigned WEIGHT_BW_DEF   = 8;
  localparam int unsigned MATRIX_SIZE_DEF = 8;
  localparam int unsigned FIFO_DEPTH_DEF  = 8;

  // Bubble cycles after the last pop so the far lane empties out
  localparam int unsigned DRAIN_CYCLES = MATRIX_SIZE_DEF - 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD_W = 2'd1,
    ST_STREAM = 2'd2,
    ST_DRAIN  = 2'd3
  } state_e;

endpackage

// File: rtl/sysarr_vec_fifo.sv
// Synchronous vector FIFO; extra pointer bit distinguishes full from empty.
module sysarr_vec_fifo #(
  parameter int unsigned WIDTH = 65,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data_c,
  output logic             full_c,
  output logic             empty_c
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  assign full_c    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_c   = (wr_ptr_q == rd_ptr_q);
  assign rd_data_c = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance and storage write; full/empty gate the requests
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push && !full_c) begin
      mem_d[wr_ptr_q[AW-1:0]] = wr_data;
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (pop && !empty_c) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  // FIFO state registers; reset clears contents as well as pointers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/sysarr_input_feeder.sv
// Feeds the PE chain: loads one weight vector, then streams buffered
// activation vectors with lane k skewed by k cycles, then drains.
module sysarr_input_feeder
  import sysarr_pkg::*;
#(
  parameter int unsigned DATA_BW     = DATA_BW_DEF,
  parameter int unsigned WEIGHT_BW   = WEIGHT_BW_DEF,
  parameter int unsigned MATRIX_SIZE = MATRIX_SIZE_DEF,
  parameter int unsigned FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           w_valid,
  input  logic [MATRIX_SIZE*WEIGHT_BW-1:0] w_data,
  output logic                           w_ready,
  input  logic                           in_valid,
  input  logic [DATA_BW*MATRIX_SIZE-1:0] in_data,
  input  logic                           in_last,
  output logic                           in_ready,
  output logic [MATRIX_SIZE*WEIGHT_BW-1:0] WEIGHTS,
  output logic                           we_rl,
  output logic [DATA_BW*MATRIX_SIZE-1:0] DIN,
  output logic [MATRIX_SIZE-1:0]         din_valid,
  output logic                           busy,
  output logic                           done
);

  localparam int unsigned VEC_W    = DATA_BW * MATRIX_SIZE;
  localparam int unsigned WGT_W    = WEIGHT_BW * MATRIX_SIZE;
  localparam int unsigned DRAIN_LP = MATRIX_SIZE - 1;
  localparam int unsigned CNT_W    = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;

  state_e             state_q, state_d;
  logic [WGT_W-1:0]   weights_q, weights_d;
  logic               we_rl_q, we_rl_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               fifo_full_c, fifo_empty_c, fifo_pop_c;
  logic [VEC_W:0]     fifo_rd_c;
  logic [VEC_W-1:0]   stage_data_c;
  logic               stage_vld_c;

  assign w_ready  = (state_q == ST_IDLE);
  assign in_ready = !fifo_full_c;
  assign WEIGHTS  = weights_q;
  assign we_rl    = we_rl_q;
  assign busy     = busy_q;
  assign done     = done_q;

  sysarr_vec_fifo #(
    .WIDTH (VEC_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (in_valid),
    .wr_data   ({in_data, in_last}),
    .pop       (fifo_pop_c),
    .rd_data_c (fifo_rd_c),
    .full_c    (fifo_full_c),
    .empty_c   (fifo_empty_c)
  );

  // Sequencer: weight load, stream pops, drain countdown
  always_comb begin
    state_d      = state_q;
    weights_d    = weights_q;
    we_rl_d      = 1'b0;
    done_d       = 1'b0;
    cnt_d        = cnt_q;
    fifo_pop_c   = 1'b0;
    stage_data_c = '0;
    stage_vld_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_valid) begin
          weights_d = w_data;
          state_d   = ST_LOAD_W;
        end
      end
      ST_LOAD_W: begin
        we_rl_d = 1'b1;
        state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (!fifo_empty_c) begin
          fifo_pop_c   = 1'b1;
          stage_data_c = fifo_rd_c[VEC_W:1];
          stage_vld_c  = 1'b1;
          if (fifo_rd_c[0]) begin
            if (DRAIN_LP == 0) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_DRAIN;
              cnt_d   = CNT_W'(DRAIN_LP);
            end
          end
        end
      end
      ST_DRAIN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Control and weight registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      weights_q <= '0;
      we_rl_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      weights_q <= weights_d;
      we_rl_q   <= we_rl_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
    end
  end

  // Skew triangle: lane k is a (k+1)-deep shift register of data+valid
  for (genvar k = 0; k < int'(MATRIX_SIZE); k++) begin : g_lane
    localparam int unsigned LANE_LSB = (MATRIX_SIZE - 1 - k) * DATA_BW;

    logic [(k+1)*DATA_BW-1:0] sr_data_q, sr_data_d;
    logic [k:0]               sr_vld_q, sr_vld_d;

    if (k == 0) begin : g_first
      // Lane 0 is just the stage-0 register
      always_comb begin
        sr_data_d = stage_data_c[LANE_LSB +: DATA_BW];
        sr_vld_d  = stage_vld_c;
      end
    end else begin : g_rest
      // New entry enters at the top, output taken from the bottom
      always_comb begin
        sr_data_d = {stage_data_c[LANE_LSB +: DATA_BW], sr_data_q[(k+1)*DATA_BW-1:DATA_BW]};
        sr_vld_d  = {stage_vld_c, sr_vld_q[k:1]};
      end
    end

    // Lane shift registers
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        sr_data_q <= '0;
        sr_vld_q  <= '0;
      end else begin
        sr_data_q <= sr_data_d;
        sr_vld_q  <= sr_vld_d;
      end
    end

    assign DIN[LANE_LSB +: DATA_BW] = sr_data_q[DATA_BW-1:0];
    assign din_valid[k]             = sr_vld_q[0];
  end

endmodule

// File: tb/tb_sysarr_input_feeder.sv
// Directed bench with a vector scoreboard for sysarr_input_feeder.
module tb_sysarr_input_feeder;

  localparam int DW = 8;
  localparam int M  = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          w_valid;
  logic [63:0]   w_data;
  logic          w_ready;
  logic          in_valid;
  logic [63:0]   in_data;
  logic          in_last;
  logic          in_ready;
  logic [63:0]   WEIGHTS;
  logic          we_rl;
  logic [63:0]   DIN;
  logic [M-1:0]  din_valid;
  logic          busy;
  logic          done;

  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            done_cnt = 0;
  logic [63:0]   vec_q [$];
  int            lane0_cyc [$];
  int            rd_idx [M];

  sysarr_input_feeder #(
    .DATA_BW     (DW),
    .WEIGHT_BW   (8),
    .MATRIX_SIZE (M),
    .FIFO_DEPTH  (8)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .w_valid   (w_valid),
    .w_data    (w_data),
    .w_ready   (w_ready),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .WEIGHTS   (WEIGHTS),
    .we_rl     (we_rl),
    .DIN       (DIN),
    .din_valid (din_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, sample 1 time unit later, and run the scoreboard
  task automatic step();
    logic [7:0]  lane;
    logic [7:0]  exp_lane;
    logic [63:0] v;
    @(posedge clk);
    #1;
    cyc++;
    if (rstn) begin
      if (done) done_cnt++;
      for (int k = 0; k < M; k++) begin
        lane = DIN[(M-1-k)*DW +: DW];
        if (din_valid[k]) begin
          if (rd_idx[k] < vec_q.size()) begin
            v = vec_q[rd_idx[k]];
            exp_lane = v[(M-1-k)*DW +: DW];
            chk($sformatf("lane%0d_data", k), 64'(lane), 64'(exp_lane));
            if (k == 0) lane0_cyc.push_back(cyc);
            else if (rd_idx[k] < lane0_cyc.size())
              chk($sformatf("lane%0d_skew", k), 64'(cyc), 64'(lane0_cyc[rd_idx[k]] + k));
            else
              chk($sformatf("lane%0d_before_lane0", k), 64'd1, 64'd0);
            rd_idx[k]++;
          end else begin
            chk($sformatf("lane%0d_unexpected_valid", k), 64'd1, 64'd0);
          end
        end else begin
          chk($sformatf("lane%0d_bubble_zero", k), 64'(lane), 64'd0);
        end
      end
    end
  endtask

  task automatic push(input logic [63:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 40) begin
      step();
      n++;
    end
    chk("push_ready", 64'(in_ready), 64'd1);
    vec_q.push_back(d);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic load_weight(input logic [63:0] w);
    w_valid = 1'b1;
    w_data  = w;
    step();
    w_valid = 1'b0;
    step();
    step();
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 40) begin
      step();
      n++;
    end
    chk(tag, 64'(done), 64'd1);
  endtask

  task automatic sb_drained(input string tag);
    for (int k = 0; k < M; k++)
      chk($sformatf("%s_lane%0d_consumed", tag, k), 64'(rd_idx[k]), 64'(vec_q.size()));
  endtask

  task automatic sb_clear();
    vec_q.delete();
    lane0_cyc.delete();
    for (int k = 0; k < M; k++) rd_idx[k] = 0;
  endtask

  initial begin
    int          e1;
    logic [63:0] r;
    logic [63:0] d9;
    logic [M-1:0] expv;

    rstn = 1'b0; w_valid = 1'b0; w_data = '0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    sb_clear();
    step();
    step();

    // Reset values
    chk("rst_weights", WEIGHTS, 64'd0);
    chk("rst_we_rl", 64'(we_rl), 64'd0);
    chk("rst_din", DIN, 64'd0);
    chk("rst_din_valid", 64'(din_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    #2 rstn = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_w_ready", 64'(w_ready), 64'd1);

    // Weight load and one-cycle strobe
    w_valid = 1'b1;
    w_data  = 64'h0102030405060708;
    step();
    w_valid = 1'b0;
    chk("t1_weights", WEIGHTS, 64'h0102030405060708);
    chk("t1_we_rl_early", 64'(we_rl), 64'd0);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_w_ready_low", 64'(w_ready), 64'd0);
    step();
    chk("t1_we_rl_high", 64'(we_rl), 64'd1);
    step();
    chk("t1_we_rl_low", 64'(we_rl), 64'd0);
    chk("t1_busy_stream", 64'(busy), 64'd1);

    // Three back-to-back vectors, last on the third
    push(64'h1111111111111111, 1'b0);
    e1 = cyc;
    push(64'h2222222222222222, 1'b0);
    push(64'h3333333333333333, 1'b1);
    wait_done("t2_done_seen");
    chk("t2_done_cycle", 64'(cyc), 64'(e1 + 3 + int'(sysarr_pkg::DRAIN_CYCLES)));
    chk("t2_lane7_at_done", 64'(din_valid[M-1]), 64'd1);
    chk("t2_busy_at_done", 64'(busy), 64'd0);
    chk("t2_lane0_latency", 64'(lane0_cyc[0]), 64'(e1 + 1));
    step();
    chk("t2_done_pulse", 64'(done), 64'd0);
    sb_drained("t2");

    // Fill FIFO while idle; the ninth vector waits for the first pop
    for (int i = 0; i < 8; i++) begin
      r = {$urandom(), $urandom()};
      push(r, 1'b0);
    end
    chk("t3_full", 64'(in_ready), 64'd0);
    chk("t3_idle", 64'(busy), 64'd0);
    d9 = {$urandom(), $urandom()};
    in_valid = 1'b1; in_data = d9; in_last = 1'b1;
    w_valid = 1'b1; w_data = 64'hA5A55A5AC3C33C3C;
    step();
    w_valid = 1'b0;
    chk("t3_full_hs", 64'(in_ready), 64'd0);
    chk("t3_weights", WEIGHTS, 64'hA5A55A5AC3C33C3C);
    step();
    chk("t3_full_loadw", 64'(in_ready), 64'd0);
    step();
    chk("t3_ready_after_pop", 64'(in_ready), 64'd1);
    vec_q.push_back(d9);
    step();
    in_valid = 1'b0; in_last = 1'b0;
    wait_done("t3_done_seen");
    step();
    sb_drained("t3");
    chk("t3_done_count", 64'(done_cnt), 64'd2);

    // Two-cycle gap between pushes propagates diagonally
    load_weight(64'h0F0E0D0C0B0A0908);
    for (int j = 0; j < 12; j++) begin
      in_valid = (j == 0 || j == 3);
      in_data  = (j == 0) ? 64'h0123456789ABCDEF : 64'hFEDCBA9876543210;
      in_last  = (j == 3);
      if (in_valid) vec_q.push_back(in_data);
      step();
      for (int k = 0; k < M; k++) expv[k] = (j == k + 1) || (j == k + 4);
      chk($sformatf("t4_valid_j%0d", j), 64'(din_valid), 64'(expv));
      chk($sformatf("t4_done_j%0d", j), 64'(done), 64'(j == 11));
    end
    in_valid = 1'b0; in_last = 1'b0;
    step();
    sb_drained("t4");
    chk("t4_done_count", 64'(done_cnt), 64'd3);

    // Reset during drain with a prefetched vector in the FIFO
    load_weight(64'h1122334455667788);
    push(64'hDEADBEEFCAFEF00D, 1'b1);
    push(64'h5555AAAA5555AAAA, 1'b0);
    step();
    step();
    chk("t5_busy_drain", 64'(busy), 64'd1);
    chk("t5_no_done_yet", 64'(done), 64'd0);
    #1 rstn = 1'b0;
    #1;
    chk("t5_rst_weights", WEIGHTS, 64'd0);
    chk("t5_rst_we_rl", 64'(we_rl), 64'd0);
    chk("t5_rst_din", DIN, 64'd0);
    chk("t5_rst_din_valid", 64'(din_valid), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_done", 64'(done), 64'd0);
    chk("t5_rst_in_ready", 64'(in_ready), 64'd1);
    sb_clear();
    step();
    step();
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("t5_quiet_%0d", i), 64'(din_valid), 64'd0);
    end
    chk("t5_no_done", 64'(done_cnt), 64'd3);
    load_weight(64'h8877665544332211);
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("t5_fifo_empty_%0d", i), 64'(din_valid), 64'd0);
    end

    // Weight offer during streaming is refused
    w_valid = 1'b1;
    w_data  = 64'hFFFFFFFFFFFFFFFF;
    #1;
    chk("t6_w_ready", 64'(w_ready), 64'd0);
    step();
    chk("t6_weights_hold", WEIGHTS, 64'h8877665544332211);
    chk("t6_no_we_rl", 64'(we_rl), 64'd0);
    step();
    w_valid = 1'b0;
    chk("t6_weights_hold2", WEIGHTS, 64'h8877665544332211);
    chk("t6_busy", 64'(busy), 64'd1);
    push(64'h0807060504030201, 1'b1);
    wait_done("t6_done_seen");
    step();
    sb_drained("t6");
    chk("t6_done_count", 64'(done_cnt), 64'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
